// File: rtl/enum_accum_fsm.sv
// Multi-beat reducer (SUM/XOR/MAX/MIN) driven by a four-state FSM; the result appears
// one cycle after the last beat. Beats stall on in_valid=0 with no timeout.
module enum_accum_fsm #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [COUNT_W-1:0] length,
    input  logic [WIDTH-1:0]   in1,
    input  logic               in_valid,
    output logic [WIDTH-1:0]   out1,
    output logic               out_valid,
    output logic               overflow,
    output logic               busy,
    output logic [1:0]         fsm_state
);

    typedef enum logic [1:0] {
        INITIAL = 2'd0,
        START   = 2'd1,
        ACCUM   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [1:0] OP_SUM = 2'd0;
    localparam logic [1:0] OP_XOR = 2'd1;
    localparam logic [1:0] OP_MAX = 2'd2;

    state_t             state, state_nxt;
    logic [1:0]         op_q, op_nxt;
    logic [COUNT_W-1:0] count, count_nxt;
    logic [WIDTH-1:0]   acc, acc_nxt, out1_nxt, beat_val;
    logic [WIDTH:0]     sum_ext;
    logic               ovf, ovf_nxt, first, first_nxt;
    logic               out_valid_nxt, overflow_nxt;

    assign sum_ext = {1'b0, acc} + {1'b0, in1};

    // The first beat seeds the accumulator regardless of operation.
    always_comb begin
        beat_val = in1;
        if (!first) begin
            case (op_q)
                OP_SUM:  beat_val = sum_ext[WIDTH-1:0];
                OP_XOR:  beat_val = acc ^ in1;
                OP_MAX:  beat_val = (in1 > acc) ? in1 : acc;
                default: beat_val = (in1 < acc) ? in1 : acc;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        op_nxt        = op_q;
        count_nxt     = count;
        acc_nxt       = acc;
        ovf_nxt       = ovf;
        first_nxt     = first;
        out1_nxt      = out1;
        overflow_nxt  = overflow;
        out_valid_nxt = 1'b0;
        case (state)
            INITIAL: state_nxt = START;
            START: begin
                if (start) begin
                    op_nxt    = op;
                    count_nxt = length;
                    acc_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    first_nxt = 1'b1;
                    if (length == '0) begin
                        state_nxt     = DONE;
                        out1_nxt      = '0;
                        overflow_nxt  = 1'b0;
                        out_valid_nxt = 1'b1;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_nxt   = beat_val;
                    first_nxt = 1'b0;
                    count_nxt = count - COUNT_W'(1);
                    if (op_q == OP_SUM && !first && sum_ext[WIDTH])
                        ovf_nxt = 1'b1;
                    // Result register loads on the final beat so it is valid in DONE.
                    if (count == COUNT_W'(1)) begin
                        state_nxt     = DONE;
                        out1_nxt      = beat_val;
                        overflow_nxt  = ovf_nxt;
                        out_valid_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INITIAL;
            op_q      <= 2'd0;
            count     <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            first     <= 1'b0;
            out1      <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            op_q      <= op_nxt;
            count     <= count_nxt;
            acc       <= acc_nxt;
            ovf       <= ovf_nxt;
            first     <= first_nxt;
            out1      <= out1_nxt;
            overflow  <= overflow_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    assign busy      = (state == ACCUM);
    assign fsm_state = state;

endmodule

// File: tb/tb_enum_accum_fsm.sv
// Directed bench for enum_accum_fsm with hand-computed results.
module tb_enum_accum_fsm;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [1:0]  op;
    logic [7:0]  length;
    logic [31:0] in1, out1;
    logic        out_valid, overflow, busy;
    logic [1:0]  fsm_state;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] bt [256];

    always #5 clk = ~clk;

    enum_accum_fsm #(.WIDTH(32), .COUNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .length(length),
        .in1(in1), .in_valid(in_valid), .out1(out1), .out_valid(out_valid),
        .overflow(overflow), .busy(busy), .fsm_state(fsm_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Start an op and feed beats from bt[]; during gaps start is held high to show it is ignored.
    task automatic do_op(input logic [1:0] o, input int len, input int gap);
        start  = 1'b1;
        op     = o;
        length = len[7:0];
        step();
        start = 1'b0;
        if (len == 0) return;
        chk("busy_accum", {31'd0, busy}, 32'd1);
        for (int i = 0; i < len; i++) begin
            repeat (gap) begin
                start  = 1'b1;
                op     = 2'd0;
                length = 8'd0;
                step();
            end
            start    = 1'b0;
            in1      = bt[i];
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            in1      = 32'hDEAD_BEEF;
        end
    endtask

    task automatic chk_result(input string tag, input logic [31:0] exp_out, input logic exp_ovf);
        chk({tag, "_vld"},   {31'd0, out_valid}, 32'd1);
        chk({tag, "_state"}, {30'd0, fsm_state}, 32'd3);
        chk({tag, "_out"},   out1, exp_out);
        chk({tag, "_ovf"},   {31'd0, overflow}, {31'd0, exp_ovf});
        step();
        chk({tag, "_vld_end"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_back"},    {30'd0, fsm_state}, 32'd1);
        chk({tag, "_hold"},    out1, exp_out);
        chk({tag, "_ovfhold"}, {31'd0, overflow}, {31'd0, exp_ovf});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; op = 2'd0; length = 8'd0; in1 = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", {30'd0, fsm_state}, 32'd0);
        chk("rst_out",   out1, 32'd0);
        chk("rst_vld",   {31'd0, out_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        reset = 1'b0;
        step();
        chk("rel_state", {30'd0, fsm_state}, 32'd1);

        bt[0] = 32'd5; bt[1] = 32'd7; bt[2] = 32'd9;
        do_op(2'd0, 3, 0);
        chk_result("sum3", 32'd21, 1'b0);

        bt[0] = 32'hFFFF_FFFF; bt[1] = 32'h2;
        do_op(2'd0, 2, 0);
        chk_result("sum_ovf", 32'h1, 1'b1);

        bt[0] = 32'd3; bt[1] = 32'h8000_0000; bt[2] = 32'd7; bt[3] = 32'd1;
        do_op(2'd2, 4, 2);
        chk_result("max", 32'h8000_0000, 1'b0);
        do_op(2'd3, 4, 2);
        chk_result("min", 32'h1, 1'b0);

        bt[0] = 32'hF0; bt[1] = 32'h3C; bt[2] = 32'h01;
        do_op(2'd1, 3, 1);
        chk_result("xor", 32'hCD, 1'b0);

        do_op(2'd0, 0, 0);
        chk_result("len0", 32'd0, 1'b0);

        for (int i = 0; i < 256; i++) bt[i] = 32'd1;
        do_op(2'd0, 255, 0);
        chk_result("len_max", 32'd255, 1'b0);

        // Abort after 2 of 5 beats; reset wins over a simultaneous beat.
        bt[0] = 32'd10; bt[1] = 32'd20;
        start = 1'b1; op = 2'd0; length = 8'd5;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in1 = bt[i]; in_valid = 1'b1;
            step();
        end
        reset = 1'b1; in1 = 32'd30; start = 1'b1;
        step();
        chk("abort_state", {30'd0, fsm_state}, 32'd0);
        chk("abort_out",   out1, 32'd0);
        chk("abort_vld",   {31'd0, out_valid}, 32'd0);
        chk("abort_busy",  {31'd0, busy}, 32'd0);
        reset = 1'b0; in_valid = 1'b0; start = 1'b0;
        step();
        chk("abort_start", {30'd0, fsm_state}, 32'd1);
        chk("abort_novld", {31'd0, out_valid}, 32'd0);
        step();
        chk("abort_idle",  {30'd0, fsm_state}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
